// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   Pixel-timing sequencer for the VGA datapath. It divides clk by CLK_DIV to
//   make a one-cycle pixel strobe, runs the horizontal and vertical counters on
//   that strobe, and decodes hsync, vsync and vidon from the registered
//   counters. The defaults give 640x480 @ 60 Hz (800x521 total) from 100 MHz.
//
//   Optional feature: define VGA_FRAME_CNT_EN to build the 8-bit
//   completed-frame counter. When it is not defined, frame_cnt is tied to 0.
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous reset, active low (overrides en)
//   en           in   run enable; low freezes the divider and all counters
//   hc, vc       out  horizontal / vertical counters (11 bit)
//   hsync, vsync out  active-low sync pulses
//   vidon        out  high inside the visible window
//   pix_en       out  one-clock pixel strobe
//   line_end     out  strobe on the pixel edge that wraps hc
//   frame_start  out  strobe on the pixel edge that wraps both hc and vc
//   frame_cnt    out  completed-frame counter, modulo 256
module vga_timing_ctrl #(
    parameter int CLK_DIV = 4,
    parameter int HPIXELS = 800,
    parameter int VLINES  = 521,
    parameter int HSP     = 96,
    parameter int HBP     = 144,
    parameter int HFP     = 784,
    parameter int VSP     = 2,
    parameter int VBP     = 31,
    parameter int VFP     = 511
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] hc,
    output logic [10:0] vc,
    output logic        hsync,
    output logic        vsync,
    output logic        vidon,
    output logic        pix_en,
    output logic        line_end,
    output logic        frame_start,
    output logic [7:0]  frame_cnt
);

    if (CLK_DIV < 1 || HPIXELS > 2047 || VLINES > 2047 || HPIXELS < 1 || VLINES < 1) begin : g_bad_params
        $error("vga_timing_ctrl: CLK_DIV must be >= 1 and HPIXELS/VLINES in 1..2047");
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0]      H_LAST   = 11'(HPIXELS - 1);
    localparam logic [10:0]      V_LAST   = 11'(VLINES - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [10:0]      hc_q, hc_d;
    logic [10:0]      vc_q, vc_d;
    logic             h_wrap, v_wrap;

    assign h_wrap = (hc_q == H_LAST);
    assign v_wrap = (vc_q == V_LAST);

    always_comb begin
        div_d       = div_q;
        hc_d        = hc_q;
        vc_d        = vc_q;
        // Gate with rst_n so the strobes read 0 during reset even when CLK_DIV = 1.
        pix_en      = rst_n & en & (div_q == DIV_LAST);
        line_end    = pix_en & h_wrap;
        frame_start = pix_en & h_wrap & v_wrap;

        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        end

        if (pix_en) begin
            if (h_wrap) begin
                hc_d = '0;
                vc_d = v_wrap ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
            hc_q  <= '0;
            vc_q  <= '0;
        end else begin
            div_q <= div_d;
            hc_q  <= hc_d;
            vc_q  <= vc_d;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 8'd0;
`endif

    // Decoded straight from the registered counters: no added latency, and
    // the values are constant for the whole pixel period.
    assign hc    = hc_q;
    assign vc    = vc_q;
    assign hsync = (hc_q >= 11'(HSP));
    assign vsync = (vc_q >= 11'(VSP));
    assign vidon = (hc_q >= 11'(HBP)) & (hc_q < 11'(HFP)) &
                   (vc_q >= 11'(VBP)) & (vc_q < 11'(VFP));

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl. The DUT is built with a reduced raster
// (20 x 12 pixels, divide-by-4) so that full frames fit in a short run. All
// expected values below are worked out by hand for that geometry.
module tb_vga_timing_ctrl;

    localparam int CLK_DIV = 4;
    localparam int HPIXELS = 20;
    localparam int VLINES  = 12;
    localparam int HSP     = 3;
    localparam int HBP     = 5;
    localparam int HFP     = 17;
    localparam int VSP     = 2;
    localparam int VBP     = 3;
    localparam int VFP     = 10;

`ifdef VGA_FRAME_CNT_EN
    localparam int FC_ON = 1;
`else
    localparam int FC_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [10:0] hc, vc;
    logic        hsync, vsync, vidon, pix_en, line_end, frame_start;
    logic [7:0]  frame_cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    vga_timing_ctrl #(
        .CLK_DIV(CLK_DIV), .HPIXELS(HPIXELS), .VLINES(VLINES),
        .HSP(HSP), .HBP(HBP), .HFP(HFP), .VSP(VSP), .VBP(VBP), .VFP(VFP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .hc(hc), .vc(vc), .hsync(hsync), .vsync(vsync), .vidon(vidon),
        .pix_en(pix_en), .line_end(line_end), .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Advance n rising edges; return at the following falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        int frozen_bad;

        rst_n = 1'b0;
        en    = 1'b1;
        step(5);

        // Reset state, checked while rst_n is still low.
        chk("rst_hc", 32'(hc), 0);
        chk("rst_vc", 32'(vc), 0);
        chk("rst_hsync", 32'(hsync), 0);
        chk("rst_vsync", 32'(vsync), 0);
        chk("rst_vidon", 32'(vidon), 0);
        chk("rst_pix_en", 32'(pix_en), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);

        rst_n = 1'b1;
        #1;
        chk("start_pix0", 32'(pix_en), 0);
        step(1); chk("start_pix1", 32'(pix_en), 0);
        step(1); chk("start_pix2", 32'(pix_en), 0);
        step(1); chk("start_pix3", 32'(pix_en), 1);
        chk("start_hc_before", 32'(hc), 0);
        step(1); chk("first_hc", 32'(hc), 1);
        chk("first_pix_low", 32'(pix_en), 0);

        // hsync edge at HSP.
        step(4);  chk("hc2", 32'(hc), 2); chk("hsync_hc2", 32'(hsync), 0);
        step(4);  chk("hsync_hc3", 32'(hsync), 1);

        // Line wrap.
        step(64); chk("hc19", 32'(hc), 19); chk("le_idle", 32'(line_end), 0);
        step(3);  chk("le_pulse", 32'(line_end), 1);
        chk("fs_not_line", 32'(frame_start), 0);
        chk("le_hc", 32'(hc), 19);
        step(1);  chk("wrap_hc", 32'(hc), 0); chk("wrap_vc", 32'(vc), 1);
        chk("le_clear", 32'(line_end), 0);
        chk("vsync_vc1", 32'(vsync), 0);

        // vsync edge and visible window.
        step(80);  chk("vc2", 32'(vc), 2); chk("vsync_vc2", 32'(vsync), 1);
        chk("vidon_vc2", 32'(vidon), 0);
        step(80);  chk("vc3", 32'(vc), 3);
        step(16);  chk("vidon_hc4", 32'(vidon), 0);
        step(4);   chk("hc5", 32'(hc), 5); chk("vidon_hc5", 32'(vidon), 1);
        step(44);  chk("vidon_hc16", 32'(vidon), 1);
        step(4);   chk("hc17", 32'(hc), 17); chk("vidon_hc17", 32'(vidon), 0);

        // Freeze with en low for 50 clocks, divider parked at 2.
        step(2);
        en = 1'b0;
        #1;
        chk("freeze_pix", 32'(pix_en), 0);
        frozen_bad = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (pix_en !== 1'b0 || hc !== 11'd17 || vc !== 11'd3) frozen_bad++;
        end
        chk("freeze_hold", frozen_bad, 0);
        chk("freeze_vidon", 32'(vidon), 0);
        chk("freeze_hsync", 32'(hsync), 1);
        en = 1'b1;
        #1;
        chk("resume_div2", 32'(pix_en), 0);
        step(1); chk("resume_pix", 32'(pix_en), 1);
        step(1); chk("resume_hc", 32'(hc), 18); chk("resume_vc", 32'(vc), 3);

        // Last visible line against the first non-visible one.
        step(428); chk("vc9", 32'(vc), 9); chk("hc5b", 32'(hc), 5);
        chk("vidon_vc9", 32'(vidon), 1);
        step(80);  chk("vc10", 32'(vc), 10); chk("vidon_vc10", 32'(vidon), 0);

        // End of the first frame.
        step(136); chk("last_hc", 32'(hc), 19); chk("last_vc", 32'(vc), 11);
        chk("fs_idle", 32'(frame_start), 0);
        step(3);   chk("fs_pulse", 32'(frame_start), 1);
        chk("fs_le", 32'(line_end), 1);
        chk("fc_before", 32'(frame_cnt), 0);
        step(1);   chk("fs_hc", 32'(hc), 0); chk("fs_vc", 32'(vc), 0);
        chk("fs_clear", 32'(frame_start), 0);
        chk("fc_one", 32'(frame_cnt), FC_ON);

        // Second frame: the next pulse lands 959 clocks on (960-clock period).
        cnt = 0;
        while (frame_start !== 1'b1 && cnt < 2000) begin
            step(1);
            cnt++;
        end
        chk("frame_period", cnt, 959);
        step(1);
        chk("fc_two", 32'(frame_cnt), 2 * FC_ON);

        // Single-cycle reset mid-frame.
        step(428); chk("pre_rst_hc", 32'(hc), 7); chk("pre_rst_vc", 32'(vc), 5);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        #1;
        chk("rst2_hc", 32'(hc), 0);
        chk("rst2_vc", 32'(vc), 0);
        chk("rst2_pix", 32'(pix_en), 0);
        chk("rst2_le", 32'(line_end), 0);
        chk("rst2_fs", 32'(frame_start), 0);
        chk("rst2_fc", 32'(frame_cnt), 0);
        step(3); chk("rst2_pix3", 32'(pix_en), 1);
        step(1); chk("rst2_hc1", 32'(hc), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
